// File: rtl/sisc_mem_pkg.sv
// Shared definitions for the SISC data-memory responder: state encoding,
// default geometry and the index-width helper.
package sisc_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 256;

  // Smallest w (at least 1) with 2**w >= n.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dm_array.sv
// Word RAM for dm_resp: synchronous write, registered read.
// The read register is deliberately not reset; the owner masks it.
module dm_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[index] <= wdata;
    if (rd_en) rdata <= r_mem[index];
  end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: accepts one access, waits WAIT_CYC cycles, pulses ready,
// then idles one GAP cycle. Optional out-of-range error via DM_RESP_ERR_EN.
module dm_resp
  import sisc_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
`ifdef DM_RESP_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int         IDX_W    = idx_width(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  state_t              r_state, w_next;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ready, r_busy, r_rd_zero;
  logic                w_sel_we, w_oor, w_enter_resp, w_rd_en, w_wr_en;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_arr_rdata;

  // In IDLE the live request drives the array so a zero-wait read lands on time.
  assign w_sel_addr = (r_state == S_IDLE) ? addr : r_addr;
  assign w_sel_we   = (r_state == S_IDLE) ? we   : r_we;

`ifdef DM_RESP_ERR_EN
  logic r_err;
  assign w_oor = (w_sel_addr >> IDX_W) != '0;
  assign err   = r_err;
`else
  logic w_unused_hi;
  assign w_oor       = 1'b0;
  assign w_unused_hi = ^w_sel_addr;
`endif

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: if (req) begin
        if (WAIT_CYC == 0) w_next = S_RESP;
        else begin
          w_next    = S_WAIT;
          w_cnt_nxt = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_RESP;
        else               w_cnt_nxt = r_cnt - 4'd1;
      end
      S_RESP:  w_next = S_GAP;
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == S_RESP);
  assign w_rd_en      = w_enter_resp && !w_sel_we && !w_oor;
  assign w_wr_en      = (r_state == S_RESP) && r_we && !w_oor;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_zero <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
`ifdef DM_RESP_ERR_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_next == S_RESP);
      r_busy  <= (w_next == S_WAIT) || (w_next == S_RESP);
      if (r_state == S_IDLE && req) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      // Reads of out-of-range words (or none since reset) present zero.
      if (w_enter_resp && !w_sel_we) r_rd_zero <= w_oor;
`ifdef DM_RESP_ERR_EN
      r_err <= w_enter_resp && w_oor;
`endif
    end
  end

  dm_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .wr_en (w_wr_en),
    .rd_en (w_rd_en),
    .index (w_sel_addr[IDX_W-1:0]),
    .wdata (r_wdata),
    .rdata (w_arr_rdata)
  );

  assign ready = r_ready;
  assign busy  = r_busy;
  assign rdata = r_rd_zero ? '0 : w_arr_rdata;

endmodule

// File: tb/tb_dm_resp.sv
// Directed bench for dm_resp: one instance with WAIT_CYC=2 (a_*) and one with
// WAIT_CYC=0 (z_*). Define DM_RESP_ERR_EN to exercise the error output.
module tb_dm_resp;

  logic        clk, rst_f;
  logic        a_req, a_we, a_ready, a_busy;
  logic [15:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        z_req, z_we, z_ready, z_busy;
  logic [15:0] z_addr;
  logic [31:0] z_wdata, z_rdata;
`ifdef DM_RESP_ERR_EN
  logic        a_err, z_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dm_resp #(.WAIT_CYC(2)) u_a (
    .clk(clk), .rst_f(rst_f), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .ready(a_ready), .rdata(a_rdata), .busy(a_busy)
`ifdef DM_RESP_ERR_EN
    , .err(a_err)
`endif
  );

  dm_resp #(.WAIT_CYC(0)) u_z (
    .clk(clk), .rst_f(rst_f), .req(z_req), .we(z_we), .addr(z_addr), .wdata(z_wdata),
    .ready(z_ready), .rdata(z_rdata), .busy(z_busy)
`ifdef DM_RESP_ERR_EN
    , .err(z_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit r, input bit w, input logic [15:0] a,
                       input logic [31:0] d);
    if (sel) begin z_req = r; z_we = w; z_addr = a; z_wdata = d; end
    else     begin a_req = r; a_we = w; a_addr = a; a_wdata = d; end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? z_ready : a_ready;
  endfunction
  function automatic logic bsy(input bit sel);
    return sel ? z_busy : a_busy;
  endfunction
  function automatic logic [31:0] rdt(input bit sel);
    return sel ? z_rdata : a_rdata;
  endfunction

  // One access: counts cycles from the accepting edge to ready, then checks the GAP cycle.
  task automatic access(input bit sel, input bit w, input logic [15:0] a, input logic [31:0] d,
                        input int exp_lat, input bit chk_rd, input logic [31:0] exp_rd,
                        input bit exp_err, input string tag);
    int lat;
    bit got;
    @(negedge clk);
    drive(sel, 1'b1, w, a, d);
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = rdy(sel);
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy@ready"}, {31'd0, bsy(sel)}, 32'd1);
    if (chk_rd) check({tag, " rdata"}, rdt(sel), exp_rd);
`ifdef DM_RESP_ERR_EN
    check({tag, " err"}, {31'd0, sel ? z_err : a_err}, {31'd0, exp_err});
`else
    begin
      bit unused_err;
      unused_err = exp_err;
    end
`endif
    drive(sel, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    check({tag, " gap ready"}, {31'd0, rdy(sel)}, 32'd0);
    check({tag, " gap busy"},  {31'd0, bsy(sel)}, 32'd0);
  endtask

  // req held high across two reads: exactly two pulses, exp_gap cycles apart.
  task automatic hold(input bit sel, input logic [15:0] a, input logic [31:0] exp_rd,
                      input int exp_gap, input string tag);
    int n, p0, p1;
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, a, 32'h0);
    @(posedge clk);
    n = 0; p0 = 0; p1 = 0;
    for (int i = 1; i <= 2 * exp_gap; i++) begin
      @(negedge clk);
      if (rdy(sel)) begin
        n++;
        if (n == 1) p0 = i; else p1 = i;
        check({tag, " rdata"}, rdt(sel), exp_rd);
      end
    end
    drive(sel, 1'b0, 1'b0, 16'h0, 32'h0);
    check({tag, " pulses"}, 32'(n), 32'd2);
    check({tag, " spacing"}, 32'(p1 - p0), 32'(exp_gap));
  endtask

  initial begin
    rst_f = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
    #12;
    check("rst a ready", {31'd0, a_ready}, 32'd0);
    check("rst a busy",  {31'd0, a_busy},  32'd0);
    check("rst a rdata", a_rdata, 32'd0);
    check("rst z ready", {31'd0, z_ready}, 32'd0);
    check("rst z rdata", z_rdata, 32'd0);
    @(negedge clk);
    rst_f = 1'b1;

    access(1'b0, 1'b1, 16'h0010, 32'h12345678, 3, 1'b1, 32'h0, 1'b0, "a wr 0010");
    access(1'b0, 1'b0, 16'h0010, 32'h0, 3, 1'b1, 32'h12345678, 1'b0, "a rd 0010");

    access(1'b1, 1'b1, 16'h0000, 32'h1, 1, 1'b1, 32'h0, 1'b0, "z wr 0");
    access(1'b1, 1'b0, 16'h0000, 32'h0, 1, 1'b1, 32'h1, 1'b0, "z rd 0");
    hold(1'b1, 16'h0000, 32'h1, 3, "z hold");
    hold(1'b0, 16'h0010, 32'h12345678, 5, "a hold");

    // Aborted write: reset mid-WAIT must not commit DEADBEEF.
    access(1'b0, 1'b1, 16'h0005, 32'h0BADF00D, 3, 1'b0, 32'h0, 1'b0, "a wr 5");
    access(1'b0, 1'b0, 16'h0005, 32'h0, 3, 1'b1, 32'h0BADF00D, 1'b0, "a rd 5");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0005, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    check("abort busy wait", {31'd0, a_busy}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    #1 rst_f = 1'b0;
    #1;
    check("abort ready", {31'd0, a_ready}, 32'd0);
    check("abort busy",  {31'd0, a_busy},  32'd0);
    check("abort rdata", a_rdata, 32'd0);
    @(negedge clk);
    rst_f = 1'b1;
    access(1'b0, 1'b0, 16'h0005, 32'h0, 3, 1'b1, 32'h0BADF00D, 1'b0, "a rd 5 after abort");

`ifdef DM_RESP_ERR_EN
    access(1'b0, 1'b1, 16'h0000, 32'hCAFE0000, 3, 1'b0, 32'h0, 1'b0, "err wr 0");
    access(1'b0, 1'b1, 16'h0100, 32'h77777777, 3, 1'b0, 32'h0, 1'b1, "err wr 0100");
    access(1'b0, 1'b0, 16'h0000, 32'h0, 3, 1'b1, 32'hCAFE0000, 1'b0, "err rd 0");
    access(1'b0, 1'b0, 16'h0100, 32'h0, 3, 1'b1, 32'h0, 1'b1, "err rd 0100");
`else
    access(1'b0, 1'b1, 16'h0103, 32'hA5A5A5A5, 3, 1'b0, 32'h0, 1'b0, "wrap wr 0103");
    access(1'b0, 1'b0, 16'h0003, 32'h0, 3, 1'b1, 32'hA5A5A5A5, 1'b0, "wrap rd 0003");
    access(1'b0, 1'b0, 16'h0010, 32'h0, 3, 1'b1, 32'h12345678, 1'b0, "wrap rd 0010");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_resp.md
Name: dm_resp

Overview:
- Data-memory responder for the SISC datapath, on the far side of the control unit's memory-access signals.
- Accepts a read or write request from the controller side, inserts a programmable number of wait states, then completes with a one-cycle ready pulse.
- Lets the control FSM be extended to stall in its mem state until the memory acknowledges.
- Holds the word array internally.

Parameters:
- ADDR_W, 16, address width (matches instr[15:0] immediate field).
- DATA_W, 32, data word width.
- DEPTH, 256, number of words implemented; must be power of two, <= 2**ADDR_W.
- WAIT_CYC, 2, wait states inserted between acceptance and ready; legal range 0..15.

Ports:
- clk  input  1  system clock, posedge active.
- rst_f  input  1  asynchronous active-low reset.
- req  input  1  access request, level; held high by requester until ready seen.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  ADDR_W  word address; sampled with req.
- wdata  input  DATA_W  write data; sampled with req.
- ready  output  1  one-cycle completion pulse.
- rdata  output  DATA_W  read data; valid from the ready cycle, held until the next read completes.
- busy  output  1  high from acceptance through the ready cycle.

Behaviour:
- Reset: rst_f low forces state IDLE, ready=0, busy=0, rdata=0 and wait counter=0, asynchronously.
  - Array contents are not cleared.
  - A reset mid-access aborts it; a pending write is not performed.
- States: IDLE, WAIT, RESP, GAP.
- IDLE:
  - On posedge with req=1, capture we/addr/wdata into holding registers and set busy=1.
  - Go to WAIT with counter=WAIT_CYC-1, or to RESP directly if WAIT_CYC=0.
- WAIT:
  - Decrement counter each cycle.
  - When counter=0, go to RESP. Requester inputs are ignored here; only the captured values are used.
- RESP:
  - ready=1 for exactly this cycle.
  - Write: array[captured addr] is updated at the posedge ending RESP.
  - Read: rdata is loaded at the posedge entering RESP, so it is valid while ready=1. rdata is unchanged by writes.
  - Next state is GAP.
- GAP:
  - One mandatory idle cycle with busy=0 and ready=0; req is not sampled.
  - Next state is IDLE. This lets the requester drop req after seeing ready without triggering a duplicate access.
- Latency: ready rises WAIT_CYC+1 cycles after the accepting edge. Back-to-back accesses take WAIT_CYC+3 cycles each.
- Address width: only addr[log2(DEPTH)-1:0] is used; higher bits wrap modulo DEPTH (unless ERR_EN is defined).
- Same-address write then read returns the new data. No read-during-write hazard exists because accesses are serialised.
- req dropping during WAIT does not cancel the access; it completes normally.
- ready and busy are registered outputs, glitch-free.

Optional Feature:
- Macro DM_RESP_ERR_EN.
- Defined:
  - Adds output err (1 bit). err is asserted together with ready when the captured addr >= DEPTH.
  - On such a write, the array is not modified. On such a read, rdata is loaded with 0.
  - err resets to 0.
- Undefined: no err port; out-of-range addresses wrap modulo DEPTH.

Decomposition:
- Shared package sisc_mem_pkg:
  - state encoding constants (IDLE=0, WAIT=1, RESP=2, GAP=3);
  - default ADDR_W, DATA_W, DEPTH;
  - a clog2-style constant function for the index width.
- One sub-module, dm_array: synchronous-write, registered-read word RAM with ports clk, wr_en, rd_en, index, wdata, rdata.
- dm_resp holds the FSM, wait counter, capture registers and optional error check.

Test Plan:
- Reset: assert rst_f=0 mid-WAIT of a write of 32'hDEADBEEF to addr 5 -> ready/busy/rdata go 0 immediately; a later read of addr 5 does not return DEADBEEF.
- Write then read (WAIT_CYC=2): write 32'h12345678 to addr 16'h0010, then read it -> ready pulses 3 cycles after each accept; rdata=12345678 during the read's ready cycle.
- Zero wait (WAIT_CYC=0): read addr 0 after writing 32'h1 -> ready 1 cycle after accept; back-to-back spacing is 3 cycles.
- req held high continuously across two reads -> exactly two ready pulses, separated by the GAP cycle; no duplicate access.
- Wrap with DEPTH=256: write 32'hA5A5A5A5 to addr 16'h0103, read addr 16'h0003 -> rdata=A5A5A5A5 (macro undefined).
- With DM_RESP_ERR_EN defined: write to addr 16'h0100 -> err=1 with ready; a read of addr 0 is unchanged; a read of addr 16'h0100 gives rdata=0 and err=1.
